wasm_mem_unit: RTL

- Load/store sequencer directly upstream of the byte-wide data memory.
- Accepts one WASM linear-memory op per handshake: i32.load, i32.load8_s/u, i32.load16_s/u, i32.store, i32.store8, i32.store16.
- Computes the effective address, bounds-checks it, and runs 1/2/4 little-endian byte accesses over a four-phase req/ack memory port.
- Returns loaded data or a trap flag to the execute stage.

---
 rtl/wasm_mem_pkg.sv | 42 ++++
 rtl/wasm_load_extend.sv | 30 +++
 rtl/wasm_mem_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wasm_mem_pkg.sv
// Shared types and op-decoding helpers for the WASM linear-memory load/store unit.
// Used by wasm_mem_unit, which has one build option: WASM_MEM_ALIGN_TRAP_EN.
package wasm_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned KIND_W = 4;

  typedef enum logic [KIND_W-1:0] {
    LD32  = 4'd0,
    LD8S  = 4'd1,
    LD8U  = 4'd2,
    LD16S = 4'd3,
    LD16U = 4'd4,
    ST32  = 4'd5,
    ST8   = 4'd6,
    ST16  = 4'd7
  } op_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic [2:0] kind_size(input logic [KIND_W-1:0] kind);
    case (kind)
      LD32, ST32:         kind_size = 3'd4;
      LD16S, LD16U, ST16: kind_size = 3'd2;
      default:            kind_size = 3'd1;
    endcase
  endfunction

  function automatic logic kind_is_store(input logic [KIND_W-1:0] kind);
    kind_is_store = (kind == ST32) || (kind == ST8) || (kind == ST16);
  endfunction

  function automatic logic kind_is_signed(input logic [KIND_W-1:0] kind);
    kind_is_signed = (kind == LD8S) || (kind == LD16S);
  endfunction

endpackage

// File: rtl/wasm_load_extend.sv
// Sign/zero extension of the little-endian assembled load bytes by op kind.
// Store kinds and illegal kinds produce zero.
module wasm_load_extend
  import wasm_mem_pkg::*;
(
  input  logic [KIND_W-1:0] kind,
  input  logic [WORD_W-1:0] raw,
  output logic [WORD_W-1:0] data_c
);

  logic sign;

  always_comb begin
    data_c = '0;
    sign   = 1'b0;
    case (kind)
      LD32: data_c = raw;
      LD8S, LD8U: begin
        sign   = kind_is_signed(kind) & raw[7];
        data_c = {{24{sign}}, raw[7:0]};
      end
      LD16S, LD16U: begin
        sign   = kind_is_signed(kind) & raw[15];
        data_c = {{16{sign}}, raw[15:0]};
      end
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/wasm_mem_unit.sv
// WASM i32 load/store sequencer driving a byte-wide four-phase memory port.
// Build option: define WASM_MEM_ALIGN_TRAP_EN to also trap misaligned accesses.
module wasm_mem_unit
  import wasm_mem_pkg::*;
#(
  parameter int unsigned ADDR  = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [KIND_W-1:0] op_kind,
  input  logic [WIDTH-1:0]  op_base,
  input  logic [WIDTH-1:0]  op_offset,
  input  logic [WIDTH-1:0]  op_wdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic              res_trap,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              mem_we,
  output logic [ADDR-1:0]   mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned EA_W = WIDTH + 1;

  state_e            state_q, state_n;
  logic [ADDR-1:0]   base_q, base_n;
  logic [1:0]        cnt_q, cnt_n, cnt_inc;
  logic [2:0]        size_q, size_n;
  logic [KIND_W-1:0] kind_q, kind_n;
  logic [WIDTH-1:0]  wdata_q, wdata_n;
  logic [WIDTH-1:0]  rbuf_q, rbuf_n;

  logic              op_ready_n, res_valid_n, res_trap_n;
  logic              mem_req_n, mem_we_n;
  logic [WIDTH-1:0]  res_data_n;
  logic [ADDR-1:0]   mem_addr_n;
  logic [7:0]        mem_wdata_n;

  logic [EA_W-1:0]   ea, last;
  logic [2:0]        op_size;
  logic              trap, accept;
  logic [WIDTH-1:0]  ext_data;

  wasm_load_extend u_ext (
    .kind   (kind_q),
    .raw    (rbuf_q),
    .data_c (ext_data)
  );

  // Effective address (with carry) and trap decision for the offered op
  always_comb begin
    op_size = kind_size(op_kind);
    ea      = EA_W'(op_base) + EA_W'(op_offset);
    last    = ea + EA_W'(op_size) - EA_W'(1);
    trap    = ((last >> ADDR) != '0) || op_kind[KIND_W-1];
`ifdef WASM_MEM_ALIGN_TRAP_EN
    trap    = trap || ((op_size == 3'd4) && (ea[1:0] != 2'b00))
                   || ((op_size == 3'd2) && ea[0]);
`endif
  end

  // A lingering ack from an op aborted by reset blocks acceptance
  assign accept = op_valid && op_ready && !mem_ack;

  always_comb begin
    state_n     = state_q;
    base_n      = base_q;
    cnt_n       = cnt_q;
    size_n      = size_q;
    kind_n      = kind_q;
    wdata_n     = wdata_q;
    rbuf_n      = rbuf_q;
    res_valid_n = res_valid;
    res_data_n  = res_data;
    res_trap_n  = res_trap;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    cnt_inc     = cnt_q + 2'd1;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (trap) begin
            state_n     = ST_RESP;
            res_valid_n = 1'b1;
            res_trap_n  = 1'b1;
            res_data_n  = '0;
          end else begin
            state_n     = ST_REQ;
            base_n      = ea[ADDR-1:0];
            size_n      = op_size;
            kind_n      = op_kind;
            wdata_n     = op_wdata;
            cnt_n       = 2'd0;
            rbuf_n      = '0;
            mem_req_n   = 1'b1;
            mem_we_n    = kind_is_store(op_kind);
            mem_addr_n  = ea[ADDR-1:0];
            mem_wdata_n = op_wdata[7:0];
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          if (!kind_is_store(kind_q)) rbuf_n[{cnt_q, 3'b000} +: 8] = mem_rdata;
          mem_req_n = 1'b0;
          state_n   = ST_REL;
        end
      end
      ST_REL: begin
        if (!mem_ack) begin
          if (3'(cnt_q) == size_q - 3'd1) begin
            state_n     = ST_RESP;
            res_valid_n = 1'b1;
            res_trap_n  = 1'b0;
            res_data_n  = ext_data;
          end else begin
            state_n     = ST_REQ;
            cnt_n       = cnt_inc;
            mem_req_n   = 1'b1;
            mem_addr_n  = base_q + ADDR'(cnt_inc);
            mem_wdata_n = wdata_q[{cnt_inc, 3'b000} +: 8];
          end
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_n     = ST_IDLE;
          res_valid_n = 1'b0;
          res_trap_n  = 1'b0;
          res_data_n  = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    op_ready_n = (state_n == ST_IDLE) && !mem_ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      kind_q    <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_trap  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_n;
      base_q    <= base_n;
      cnt_q     <= cnt_n;
      size_q    <= size_n;
      kind_q    <= kind_n;
      wdata_q   <= wdata_n;
      rbuf_q    <= rbuf_n;
      op_ready  <= op_ready_n;
      res_valid <= res_valid_n;
      res_data  <= res_data_n;
      res_trap  <= res_trap_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

endmodule
